sram_port_driver: RTL and testbench

SRAM_PORT_DRIVER -- requirements
Module: sram_port_driver

---
 rtl/sram_port_driver.sv | 129 ++++++++++++
 tb/tb_sram_port_driver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_driver.sv
// Front-end for a single-port RW0 SRAM macro. After reset the whole array is
// cleared to zero, then requests are passed straight through to the macro.
// Read data is queued in a 2-entry FIFO with a fixed two-cycle latency.
module sram_port_driver #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32,
    parameter int MASK_BITS = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    input  logic [MASK_BITS-1:0] req_wmask,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_rdata,
    output logic                 init_done,
    output logic [ADDR_BITS-1:0] RW0_addr,
    output logic                 RW0_en,
    output logic                 RW0_wmode,
    output logic [MASK_BITS-1:0] RW0_wmask,
    output logic [DATA_BITS-1:0] RW0_wdata,
    input  logic [DATA_BITS-1:0] RW0_rdata
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] counter_q, counter_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           count_q;
    logic                 rd_ptr_q, wr_ptr_q;
    logic [DATA_BITS-1:0] fifo_q [2];

    logic                 fire;
    logic                 pop;
    logic [2:0]           pending;

    assign resp_valid = (count_q != 2'd0);
    assign resp_rdata = fifo_q[rd_ptr_q];
    assign init_done  = (state_q == StRun);
    assign pop        = resp_valid & resp_ready;
    // Slots still owed to the FIFO after this cycle's pop; a new read needs one free.
    assign pending    = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign inflight_d = fire & ~req_write;

    // Next-state and SRAM port drive; reset_n gates the outputs since INIT drives RW0_en high.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        req_ready = 1'b0;
        fire      = 1'b0;
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        if (reset_n) begin
            unique case (state_q)
                StInit: begin
                    RW0_en    = 1'b1;
                    RW0_wmode = 1'b1;
                    RW0_wmask = '1;
                    RW0_addr  = counter_q;
                    // Leave INIT on the last address instead of wrapping the counter.
                    if (counter_q == '1) begin
                        state_d = StRun;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
                StRun: begin
                    req_ready = (pending < 3'd2);
                    fire      = req_valid & req_ready;
                    if (fire) begin
                        RW0_en    = 1'b1;
                        RW0_wmode = req_write;
                        RW0_addr  = req_addr;
                        RW0_wmask = req_wmask;
                        RW0_wdata = req_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register, clear counter and read-inflight flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            counter_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            inflight_q <= inflight_d;
        end
    end

    // Response FIFO: capture the macro's read data one cycle after the read fired.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= RW0_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= 2'(count_q + 2'(inflight_q) - 2'(pop));
        end
    end

    // Flow control must make a capture into a full FIFO unreachable.
    assert property (@(posedge clock) disable iff (!reset_n)
                     !(inflight_q && (count_q == 2'd2) && !pop))
        else $error("sram_port_driver: response FIFO overflow");

endmodule

// File: tb/tb_sram_port_driver.sv
// Bench for sram_port_driver: behavioural SRAM, reference memory and an
// expected-response queue with ready times, checked every negedge.
module tb_sram_port_driver;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_wmask = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          init_done;
    logic [AW-1:0] RW0_addr;
    logic          RW0_en;
    logic          RW0_wmode;
    logic [MW-1:0] RW0_wmask;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] sram_rdata = '0;

    sram_port_driver #(.ADDR_BITS(AW), .DATA_BITS(DW), .MASK_BITS(MW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural single-port SRAM macro.
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int i = 0; i < MW; i++)
                    if (RW0_wmask[i]) sram[RW0_addr][i*8 +: 8] <= RW0_wdata[i*8 +: 8];
            end else begin
                sram_rdata <= sram[RW0_addr];
            end
        end
    end

    // Reference model: memory contents as seen in fire order plus pending responses.
    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          expq [$];
    int            cyc = 0;
    int            init_cnt = 0;
    bit            s_fire = 0;
    bit            s_pop = 0;
    bit            s_wr = 0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_data = '0;
    logic [MW-1:0] s_mask = '0;

    // Compare process: derive expected outputs from the model and check the DUT.
    initial begin
        forever begin
            bit run, ev, er;
            @(negedge clock);
            if (!reset_n) begin
                s_fire = 0;
                s_pop  = 0;
                chk("rst_req_ready", 64'(req_ready), 64'd0);
                chk("rst_resp_valid", 64'(resp_valid), 64'd0);
                chk("rst_init_done", 64'(init_done), 64'd0);
                chk("rst_rw0_en", 64'(RW0_en), 64'd0);
                chk("rst_rw0_wmode", 64'(RW0_wmode), 64'd0);
            end else begin
                run = (init_cnt >= DEPTH);
                ev  = (expq.size() > 0) && (expq[0].rdy <= cyc);
                s_pop = ev && resp_ready;
                er  = run && ((expq.size() - int'(s_pop)) < 2);
                s_fire = req_valid && er;
                s_wr   = req_write;
                s_addr = req_addr;
                s_data = req_wdata;
                s_mask = req_wmask;
                chk("init_done", 64'(init_done), 64'(run));
                chk("req_ready", 64'(req_ready), 64'(er));
                chk("resp_valid", 64'(resp_valid), 64'(ev));
                if (ev) chk("resp_rdata", 64'(resp_rdata), 64'(expq[0].data));
                if (!run) begin
                    chk("init_en", 64'(RW0_en), 64'd1);
                    chk("init_wmode", 64'(RW0_wmode), 64'd1);
                    chk("init_addr", 64'(RW0_addr), 64'(init_cnt));
                    chk("init_wdata", 64'(RW0_wdata), 64'd0);
                    chk("init_wmask", 64'(RW0_wmask), 64'hF);
                end else begin
                    chk("rw0_en", 64'(RW0_en), 64'(s_fire));
                    if (s_fire) begin
                        chk("rw0_wmode", 64'(RW0_wmode), 64'(req_write));
                        chk("rw0_addr", 64'(RW0_addr), 64'(req_addr));
                        if (req_write) begin
                            chk("rw0_wdata", 64'(RW0_wdata), 64'(req_wdata));
                            chk("rw0_wmask", 64'(RW0_wmask), 64'(req_wmask));
                        end
                    end
                end
            end
        end
    end

    // Model update at each active edge using the values sampled at the negedge.
    initial begin
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                init_cnt = 0;
                expq.delete();
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end else begin
                if (init_cnt < DEPTH) init_cnt++;
                if (s_pop) void'(expq.pop_front());
                if (s_fire) begin
                    if (s_wr) begin
                        for (int i = 0; i < MW; i++)
                            if (s_mask[i]) ref_mem[s_addr][i*8 +: 8] = s_data[i*8 +: 8];
                    end else begin
                        expq.push_back('{data: ref_mem[s_addr], rdy: cyc + 2});
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Count cycles of INIT after reset release; called right after release.
    task automatic wait_init();
        int n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (init_done) break;
            n++;
        end
        chk("init_cycles", 64'(n), 64'(DEPTH));
        step();
    endtask

    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        forever begin
            @(negedge clock);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk("req_ready_timeout", 64'(req_ready), 64'd1);
                break;
            end
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [DW-1:0] d, output int lat);
        lat = 0;
        d = '0;
        resp_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (resp_valid) begin
                d = resp_rdata;
                break;
            end
            lat++;
            if (lat > 50) begin
                chk("resp_valid_timeout", 64'(resp_valid), 64'd1);
                break;
            end
        end
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        int lat;
        int fires;

        repeat (3) step();
        reset_n = 1'b1;
        wait_init();

        // Write then read of the same address on consecutive cycles.
        do_req(1'b1, 4'd5, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 4'd5, 32'h0, 4'h0);
        wait_resp(d, lat);
        chk("raw_addr5", 64'(d), 64'hDEADBEEF);
        chk("read_latency", 64'(lat), 64'd1);

        // Partial-mask overwrite keeps unmasked lanes.
        do_req(1'b1, 4'd7, 32'h11223344, 4'hF);
        do_req(1'b1, 4'd7, 32'hAABBCCDD, 4'h5);
        do_req(1'b0, 4'd7, 32'h0, 4'h0);
        wait_resp(d, lat);
        chk("masked_addr7", 64'(d), 64'h11BB33DD);

        // Backpressure: only two reads can be outstanding.
        fires = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (req_ready) fires++;
            step();
        end
        chk("fires_blocked", 64'(fires), 64'd2);
        fires = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (req_ready) fires++;
            step();
        end
        chk("fires_stream", 64'(fires), 64'd10);
        req_valid = 1'b0;
        repeat (4) step();
        resp_ready = 1'b0;

        // Reset with responses queued: they must vanish and INIT must rerun.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd5;
        repeat (3) step();
        req_valid = 1'b0;
        chk("queued_before_reset", 64'(resp_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_resp_valid", 64'(resp_valid), 64'd0);
        chk("async_req_ready", 64'(req_ready), 64'd0);
        chk("async_rw0_en", 64'(RW0_en), 64'd0);
        chk("async_init_done", 64'(init_done), 64'd0);
        repeat (3) step();
        reset_n = 1'b1;
        resp_ready = 1'b1;
        wait_init();
        repeat (3) step();

        // Random mixed traffic with random consumer backpressure.
        for (int i = 0; i < 3000; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_write  = $urandom_range(0, 1) == 1;
            req_addr   = AW'($urandom_range(0, DEPTH - 1));
            req_wdata  = $urandom;
            req_wmask  = MW'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (6) step();
        chk("drained_resp_valid", 64'(resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
